instr_bundle_asm: RTL and testbench

Sits directly downstream of the 128-bit AXI-Stream instruction input (s_axis_instr) inside sys_top, ahead of the layer controllers.
- Gathers consecutive tagged beats into one wide instruction bundle.
- Checks the beat tags for sequence errors and resynchronises after an error.
- Buffers complete bundles in a small FIFO.
- Presents bundles to the controllers over a valid/ready interface.

---
 rtl/instr_bundle_asm.sv | 219 +++++++++++++++++++++
 tb/tb_instr_bundle_asm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_bundle_asm.sv
// Instruction bundle assembler: collects four tagged 128-bit beats into one bundle,
// resynchronises on tag errors and queues finished bundles for the layer controllers.

module instr_bundle_fifo #(
  parameter int DW    = 513,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][DW-1:0] mem_q;
  logic [PW-1:0]            wr_q, rd_q;
  logic [CW-1:0]            count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Head entry comes straight from storage flops; it holds until popped.
  assign rdata = mem_q[rd_q];
  assign count = count_q;
endmodule

module instr_bundle_asm #(
  parameter int AXIS_DATA_WIDTH = 128,
  parameter int BEATS_PER_INSTR = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       s_axis_instr_tvalid,
  output logic                                       s_axis_instr_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]                 s_axis_instr_tdata,
  output logic                                       m_instr_valid,
  input  logic                                       m_instr_ready,
  output logic [BEATS_PER_INSTR*AXIS_DATA_WIDTH-1:0] m_instr_data,
  output logic                                       m_instr_last,
  output logic                                       err_seq,
  output logic [CNT_WIDTH-1:0]                       err_cnt,
  output logic [CNT_WIDTH-1:0]                       instr_cnt,
  output logic                                       busy
);
  localparam int W  = AXIS_DATA_WIDTH;
  localparam int BW = BEATS_PER_INSTR * W;
  localparam int IW = $clog2(BEATS_PER_INSTR);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BEATS_PER_INSTR - 1);

  typedef enum logic {COLLECT, RESYNC} state_t;

  typedef struct packed {
    logic          last;
    logic [BW-1:0] data;
  } bundle_t;

  state_t                           state_q, state_d;
  logic [IW-1:0]                    beat_idx_q, beat_idx_d;
  logic [BEATS_PER_INSTR-2:0][W-1:0] stg_q;
  logic                             stg_last_q;
  logic                             run_q;
  logic                             err_seq_q;
  logic [CNT_WIDTH-1:0]             err_cnt_q, instr_cnt_q;

  logic [3:0]    nib;
  logic          hdr, good, acc;
  logic          stg_wr, stg_clr, push, err_inc;
  logic [IW-1:0] stg_slot;
  logic          pop, fifo_full;
  logic [CW-1:0] fifo_count;
  bundle_t       push_b, head_b;

  assign nib  = s_axis_instr_tdata[W-1 -: 4];
  assign hdr  = (nib == 4'h8);
  assign good = (nib == {1'b1, beat_idx_q, 1'b0});

  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = m_instr_valid & m_instr_ready;

  // run_q keeps tready low while reset is held and for the first edge after.
  always_comb begin
    s_axis_instr_tready = 1'b0;
    if (run_q) begin
      if (state_q == RESYNC)            s_axis_instr_tready = 1'b1;
      else if (beat_idx_q == LAST_IDX)  s_axis_instr_tready = !fifo_full;
      else                              s_axis_instr_tready = 1'b1;
    end
  end

  assign acc = s_axis_instr_tvalid & s_axis_instr_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      beat_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    stg_wr     = 1'b0;
    stg_clr    = 1'b0;
    stg_slot   = '0;
    push       = 1'b0;
    err_inc    = 1'b0;
    if (acc) begin
      case (state_q)
        COLLECT: begin
          if (good) begin
            if (beat_idx_q == LAST_IDX) begin
              push       = 1'b1;
              beat_idx_d = '0;
            end else begin
              stg_wr     = 1'b1;
              stg_slot   = beat_idx_q;
              beat_idx_d = beat_idx_q + IW'(1);
            end
          end else begin
            err_inc = 1'b1;
            stg_clr = 1'b1;
            if (hdr) begin
              // A fresh header restarts the bundle instead of forcing resync.
              stg_wr     = 1'b1;
              beat_idx_d = IW'(1);
            end else begin
              state_d    = RESYNC;
              beat_idx_d = '0;
            end
          end
        end
        RESYNC: begin
          if (hdr) begin
            stg_wr     = 1'b1;
            beat_idx_d = IW'(1);
            state_d    = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q      <= '0;
      stg_last_q <= 1'b0;
    end else begin
      for (int k = 0; k < BEATS_PER_INSTR-1; k++) begin
        if (stg_wr && stg_slot == IW'(k)) stg_q[k] <= s_axis_instr_tdata;
        else if (stg_clr)                 stg_q[k] <= '0;
      end
      if (stg_wr && stg_slot == '0) stg_last_q <= s_axis_instr_tdata[W-8];
      else if (stg_clr)             stg_last_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      err_seq_q   <= 1'b0;
      err_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (err_inc) err_seq_q <= 1'b1;
      if (err_inc && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      if (push) instr_cnt_q <= instr_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Beat 0 sits in the LSBs; the final beat comes straight off the bus.
  assign push_b.last = stg_last_q;
  assign push_b.data = {s_axis_instr_tdata, stg_q};

  instr_bundle_fifo #(
    .DW    ($bits(bundle_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_b),
    .pop   (pop),
    .rdata (head_b),
    .count (fifo_count)
  );

  assign m_instr_valid = (fifo_count != '0);
  assign m_instr_data  = head_b.data;
  assign m_instr_last  = head_b.last;
  assign err_seq       = err_seq_q;
  assign err_cnt       = err_cnt_q;
  assign instr_cnt     = instr_cnt_q;
  assign busy          = (beat_idx_q != '0) || (fifo_count != '0) || (state_q == RESYNC);
endmodule

// File: tb/tb_instr_bundle_asm.sv
// Bench for instr_bundle_asm: beat table with scoreboarded bundles, plus backpressure
// and mid-bundle reset sequences.

module tb_instr_bundle_asm;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_axis_instr_tvalid;
  logic         s_axis_instr_tready;
  logic [127:0] s_axis_instr_tdata;
  logic         m_instr_valid;
  logic         m_instr_ready;
  logic [511:0] m_instr_data;
  logic         m_instr_last;
  logic         err_seq;
  logic [15:0]  err_cnt;
  logic [15:0]  instr_cnt;
  logic         busy;

  instr_bundle_asm dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis_instr_tvalid (s_axis_instr_tvalid),
    .s_axis_instr_tready (s_axis_instr_tready),
    .s_axis_instr_tdata  (s_axis_instr_tdata),
    .m_instr_valid       (m_instr_valid),
    .m_instr_ready       (m_instr_ready),
    .m_instr_data        (m_instr_data),
    .m_instr_last        (m_instr_last),
    .err_seq             (err_seq),
    .err_cnt             (err_cnt),
    .instr_cnt           (instr_cnt),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    bit           done;
    int           err;
  } row_t;

  typedef struct {
    logic [511:0] data;
    logic         last;
  } exp_t;

  localparam int NR = 21;
  row_t tbl [0:NR-1];
  exp_t sb [$];
  int   checks = 0, failures = 0;
  int   npushed = 0, nseen = 0, ndiscard = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] bt(input logic [1:0] idx, input logic [31:0] s);
    return {1'b1, idx, 1'b0, 92'd0, s};
  endfunction

  task automatic push_exp(input logic [511:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
    npushed++;
  endtask

  task automatic send_beat(input logic [127:0] d);
    int n = 0;
    s_axis_instr_tvalid = 1'b1;
    s_axis_instr_tdata  = d;
    @(negedge clk);
    while (!s_axis_instr_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_instr_tready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout act=tready_low exp=tready_high");
    end
    @(posedge clk);
    #1;
    s_axis_instr_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_instr_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: every handshake must match the oldest expected bundle.
  always @(negedge clk) begin
    if (rst_n && m_instr_valid && m_instr_ready) begin
      nseen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bundle act=%0h exp=none", m_instr_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("bundle_data", m_instr_data, e.data);
        chk("bundle_last", 512'(m_instr_last), 512'(e.last));
      end
    end
  end

  initial begin
    logic [127:0] b [0:3];
    int ncnt;

    b[0] = 128'h80000036001b02020201002c00060037;
    b[1] = 128'ha0000000003600c40068001800003602;
    b[2] = 128'hc0000000000008000000000320000370;
    b[3] = 128'he00000007870000077ea000078300000;
    tbl[0]  = '{b[0], 0, 0};
    tbl[1]  = '{b[1], 0, 0};
    tbl[2]  = '{b[2], 0, 0};
    tbl[3]  = '{b[3], 1, 0};
    tbl[4]  = '{128'h8100018c0024100b0200004800000090, 0, 0};
    tbl[5]  = '{b[1], 0, 0};
    tbl[6]  = '{b[2], 0, 0};
    tbl[7]  = '{b[3], 1, 0};
    tbl[8]  = '{bt(2'd0, 32'h100), 0, 0};
    tbl[9]  = '{bt(2'd1, 32'h101), 0, 0};
    tbl[10] = '{bt(2'd3, 32'h103), 0, 1};
    tbl[11] = '{bt(2'd2, 32'h102), 0, 1};
    tbl[12] = '{bt(2'd0, 32'h200), 0, 1};
    tbl[13] = '{bt(2'd1, 32'h201), 0, 1};
    tbl[14] = '{bt(2'd2, 32'h202), 0, 1};
    tbl[15] = '{bt(2'd3, 32'h203), 1, 1};
    tbl[16] = '{bt(2'd0, 32'h300), 0, 1};
    tbl[17] = '{bt(2'd0, 32'h301), 0, 2};
    tbl[18] = '{bt(2'd1, 32'h302), 0, 2};
    tbl[19] = '{bt(2'd2, 32'h303), 0, 2};
    tbl[20] = '{bt(2'd3, 32'h304), 1, 2};

    rst_n = 1'b0;
    s_axis_instr_tvalid = 1'b0;
    s_axis_instr_tdata  = '0;
    m_instr_ready = 1'b0;
    #12;
    chk("rst_tready", 512'(s_axis_instr_tready), 512'd0);
    chk("rst_valid", 512'(m_instr_valid), 512'd0);
    chk("rst_data", m_instr_data, 512'd0);
    chk("rst_last", 512'(m_instr_last), 512'd0);
    chk("rst_err_seq", 512'(err_seq), 512'd0);
    chk("rst_err_cnt", 512'(err_cnt), 512'd0);
    chk("rst_instr_cnt", 512'(instr_cnt), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    #11 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table phase: nominal, last flag, bad index + resync, header restart.
    m_instr_ready = 1'b1;
    ncnt = 0;
    for (int i = 0; i < NR; i++) begin
      if (tbl[i].done)
        push_exp({tbl[i].d, tbl[i-1].d, tbl[i-2].d, tbl[i-3].d}, tbl[i-3].d[120]);
      send_beat(tbl[i].d);
      @(negedge clk);
      chk($sformatf("err_cnt_row%0d", i), 512'(err_cnt), 512'(tbl[i].err));
      chk($sformatf("err_seq_row%0d", i), 512'(err_seq), 512'(tbl[i].err != 0));
      if (tbl[i].done) begin
        ncnt++;
        chk($sformatf("valid_lat_row%0d", i), 512'(m_instr_valid), 512'd1);
        chk($sformatf("instr_cnt_row%0d", i), 512'(instr_cnt), 512'(ncnt));
      end
      if (i == 10 || i == 11) begin
        chk($sformatf("resync_busy_row%0d", i), 512'(busy), 512'd1);
        chk($sformatf("resync_tready_row%0d", i), 512'(s_axis_instr_tready), 512'd1);
      end
      @(posedge clk);
      #1;
    end
    drain();
    chk("table_seen", 512'(nseen), 512'd4);

    // Backpressure: four bundles fill the FIFO, the fifth stalls on its final beat.
    m_instr_ready = 1'b0;
    for (int bb = 0; bb < 5; bb++) begin
      logic [127:0] q [0:3];
      for (int k = 0; k < 4; k++) q[k] = bt(2'(k), 32'(32'h400 + bb * 4 + k));
      push_exp({q[3], q[2], q[1], q[0]}, 1'b0);
      for (int k = 0; k < 3; k++) send_beat(q[k]);
      if (bb < 4) send_beat(q[3]);
      else begin
        s_axis_instr_tvalid = 1'b1;
        s_axis_instr_tdata  = q[3];
        @(negedge clk);
        chk("bp_full_tready", 512'(s_axis_instr_tready), 512'd0);
        chk("bp_busy", 512'(busy), 512'd1);
        @(posedge clk);
        #1 m_instr_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_bypass", 512'(s_axis_instr_tready), 512'd0);
        @(posedge clk);
        #1 m_instr_ready = 1'b0;
        @(negedge clk);
        chk("bp_tready_after_pop", 512'(s_axis_instr_tready), 512'd1);
        @(posedge clk);
        #1 s_axis_instr_tvalid = 1'b0;
        @(negedge clk);
        chk("bp_instr_cnt", 512'(instr_cnt), 512'd9);
        chk("bp_valid_held", 512'(m_instr_valid), 512'd1);
      end
    end
    @(posedge clk);
    #1;
    drain();

    // Reset with one bundle queued and two beats staged.
    m_instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) b[k] = bt(2'(k), 32'(32'h500 + k));
    push_exp({b[3], b[2], b[1], b[0]}, 1'b0);
    for (int k = 0; k < 4; k++) send_beat(b[k]);
    send_beat(bt(2'd0, 32'h600));
    send_beat(bt(2'd1, 32'h601));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tready", 512'(s_axis_instr_tready), 512'd0);
    chk("mid_rst_valid", 512'(m_instr_valid), 512'd0);
    chk("mid_rst_data", m_instr_data, 512'd0);
    chk("mid_rst_last", 512'(m_instr_last), 512'd0);
    chk("mid_rst_err_seq", 512'(err_seq), 512'd0);
    chk("mid_rst_err_cnt", 512'(err_cnt), 512'd0);
    chk("mid_rst_instr_cnt", 512'(instr_cnt), 512'd0);
    chk("mid_rst_busy", 512'(busy), 512'd0);
    ndiscard = ndiscard + sb.size();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) b[k] = bt(2'(k), 32'(32'h700 + k));
    b[0][120] = 1'b1;
    push_exp({b[3], b[2], b[1], b[0]}, 1'b1);
    for (int k = 0; k < 4; k++) send_beat(b[k]);
    @(negedge clk);
    chk("post_rst_instr_cnt", 512'(instr_cnt), 512'd1);
    @(posedge clk);
    #1;
    drain();
    chk("total_seen", 512'(nseen), 512'(npushed - ndiscard));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
